// File: rtl/lsu_bus_master_pkg.sv
// Shared funct3 codes and FSM state type for the load/store bus master.
package lsu_bus_master_pkg;

  localparam logic [2:0] LOAD_BYTE          = 3'b000;
  localparam logic [2:0] LOAD_HALF          = 3'b001;
  localparam logic [2:0] LOAD_WORD          = 3'b010;
  localparam logic [2:0] LOAD_BYTE_UNSIGNED = 3'b100;
  localparam logic [2:0] LOAD_HALF_UNSIGNED = 3'b101;
  localparam logic [2:0] STORE_BYTE         = 3'b000;
  localparam logic [2:0] STORE_HALF         = 3'b001;
  localparam logic [2:0] STORE_WORD         = 3'b010;

  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} lsu_state_t;

endpackage

// File: rtl/lsu_load_align.sv
// Combinational byte/half select and sign/zero extension of a raw read word.
module lsu_load_align
  import lsu_bus_master_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];

    case (funct3)
      LOAD_BYTE:          data = {{24{byte_sel[7]}}, byte_sel};
      LOAD_HALF:          data = {{16{half_sel[15]}}, half_sel};
      LOAD_BYTE_UNSIGNED: data = {24'h0, byte_sel};
      LOAD_HALF_UNSIGNED: data = {16'h0, half_sel};
      LOAD_WORD:          data = word;
      default:            data = word;
    endcase
  end

endmodule

// File: rtl/lsu_bus_master.sv
// Load/store bus initiator: IDLE -> REQ -> RSP -> DONE per access, stalling meanwhile.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned H/W accesses with fault_misaligned.
module lsu_bus_master
  import lsu_bus_master_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        fault_misaligned,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rsp_rdata,
  input  logic        bus_rsp_err
);

  lsu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       addr_lo_q, addr_lo_d;
  logic [2:0]       funct3_q, funct3_d;
  logic             req_valid_q, req_valid_d;
  logic             we_q, we_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      addr_q, addr_d, wdata_q, wdata_d;
  logic             rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, fault_q, fault_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic [3:0]       req_be;
  logic [31:0]      req_wd, load_data;
  logic             misaligned;

  lsu_load_align u_align (
    .word    (bus_rsp_rdata),
    .addr_lo (addr_lo_q),
    .funct3  (funct3_q),
    .data    (load_data)
  );

  always_comb begin
    // Bits [1:0] of funct3 give the size for both loads and stores.
    case (req_funct3[1:0])
      STORE_BYTE[1:0]: begin
        req_be = 4'b0001 << req_addr[1:0];
        req_wd = {4{req_wdata[7:0]}};
      end
      STORE_HALF[1:0]: begin
        req_be = 4'b0011 << {req_addr[1], 1'b0};
        req_wd = {2{req_wdata[15:0]}};
      end
      default: begin
        req_be = 4'b1111;
        req_wd = req_wdata;
      end
    endcase

    misaligned = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    case (req_funct3[1:0])
      STORE_BYTE[1:0]: misaligned = 1'b0;
      STORE_HALF[1:0]: misaligned = req_addr[0];
      default:         misaligned = |req_addr[1:0];
    endcase
`endif
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_lo_d   = addr_lo_q;
    funct3_d    = funct3_q;
    req_valid_d = req_valid_q;
    we_d        = we_q;
    be_d        = be_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    fault_d     = 1'b0;
    stall       = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (misaligned) begin
            fault_d = 1'b1;
          end else begin
            stall       = 1'b1;
            state_d     = REQ;
            req_valid_d = 1'b1;
            addr_d      = {req_addr[31:2], 2'b00};
            addr_lo_d   = req_addr[1:0];
            funct3_d    = req_funct3;
            we_d        = req_we;
            be_d        = req_be;
            wdata_d     = req_we ? req_wd : 32'h0;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        if (bus_req_ready) begin
          req_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = RSP;
        end
      end
      RSP: begin
        stall = 1'b1;
        if (bus_rsp_valid) begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = bus_rsp_err;
          rsp_rdata_d = we_q ? 32'h0 : load_data;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 32'h0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_lo_q   <= 2'b00;
      funct3_q    <= 3'b000;
      req_valid_q <= 1'b0;
      we_q        <= 1'b0;
      be_q        <= 4'b0000;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_lo_q   <= addr_lo_d;
      funct3_q    <= funct3_d;
      req_valid_q <= req_valid_d;
      we_q        <= we_d;
      be_q        <= be_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      fault_q     <= fault_d;
    end
  end

  assign bus_req_valid    = req_valid_q;
  assign bus_we           = we_q;
  assign bus_be           = be_q;
  assign bus_addr         = addr_q;
  assign bus_wdata        = wdata_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_err          = rsp_err_q;
  assign rsp_rdata        = rsp_rdata_q;
  assign fault_misaligned = fault_q;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Directed self-checking bench for lsu_bus_master (default parameters).
module tb_lsu_bus_master;

  logic        clk, reset;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        stall, rsp_valid, rsp_err, fault_misaligned;
  logic [31:0] rsp_rdata;
  logic        bus_req_valid, bus_req_ready, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_rsp_valid, bus_rsp_err;
  logic [31:0] bus_rsp_rdata;

  int checks = 0;
  int failures = 0;

  // Observations returned by run_access.
  logic        o_bvalid, o_bwe, o_bus_ok, o_stall_ok, o_pulse, o_err;
  logic [3:0]  o_be;
  logic [31:0] o_baddr, o_bwdata, o_rdata;

  lsu_bus_master dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_we           (req_we),
    .req_funct3       (req_funct3),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .stall            (stall),
    .rsp_valid        (rsp_valid),
    .rsp_rdata        (rsp_rdata),
    .rsp_err          (rsp_err),
    .fault_misaligned (fault_misaligned),
    .bus_req_valid    (bus_req_valid),
    .bus_req_ready    (bus_req_ready),
    .bus_addr         (bus_addr),
    .bus_we           (bus_we),
    .bus_be           (bus_be),
    .bus_wdata        (bus_wdata),
    .bus_rsp_valid    (bus_rsp_valid),
    .bus_rsp_rdata    (bus_rsp_rdata),
    .bus_rsp_err      (bus_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  // One complete access from IDLE: request, ready after ready_wait cycles, response next cycle.
  task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input int ready_wait,
                            input logic [31:0] rdata, input logic err);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    bus_req_ready = 1'b0;
    #1 o_stall_ok = (stall === 1'b1);
    cyc;
    o_bvalid = bus_req_valid; o_bwe = bus_we; o_be = bus_be;
    o_baddr = bus_addr; o_bwdata = bus_wdata;
    req_valid = 1'b0;
    o_bus_ok = 1'b1;
    #1 if (stall !== 1'b1) o_stall_ok = 1'b0;
    repeat (ready_wait) begin
      cyc;
      if (bus_req_valid !== 1'b1 || bus_be !== o_be || bus_addr !== o_baddr ||
          bus_wdata !== o_bwdata || bus_we !== o_bwe) o_bus_ok = 1'b0;
      if (stall !== 1'b1) o_stall_ok = 1'b0;
    end
    bus_req_ready = 1'b1;
    cyc;
    bus_req_ready = 1'b0;
    if (bus_req_valid !== 1'b0) o_bus_ok = 1'b0;
    if (stall !== 1'b1 || rsp_valid !== 1'b0) o_stall_ok = 1'b0;
    bus_rsp_valid = 1'b1; bus_rsp_rdata = rdata; bus_rsp_err = err;
    cyc;
    bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0;
    o_pulse = (rsp_valid === 1'b1); o_rdata = rsp_rdata; o_err = rsp_err;
    if (stall !== 1'b0) o_stall_ok = 1'b0;
    cyc;
    if (rsp_valid !== 1'b0) o_pulse = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if ({bus_req_valid, bus_we, bus_be, bus_addr, bus_wdata} !== 70'h0) begin
      failures++;
      $display("FAIL reset_bus: got %b %b %h %h %h, want all 0",
               bus_req_valid, bus_we, bus_be, bus_addr, bus_wdata);
    end
    checks++;
    if ({rsp_valid, rsp_rdata, rsp_err, fault_misaligned, stall} !== 36'h0) begin
      failures++;
      $display("FAIL reset_rsp: got v=%b d=%h e=%b f=%b s=%b, want all 0",
               rsp_valid, rsp_rdata, rsp_err, fault_misaligned, stall);
    end
  endtask

  task automatic test_store;
    run_access(1'b1, 3'b000, 32'h0000_0102, 32'h1234_56AB, 0, 32'hDEAD_BEEF, 1'b0);
    checks++;
    if ({o_bvalid, o_bwe, o_be, o_baddr, o_bwdata} !== {1'b1, 1'b1, 4'b0100, 32'h100, 32'hABAB_ABAB}) begin
      failures++;
      $display("FAIL sb_bus: got v=%b we=%b be=%b a=%h d=%h, want 1 1 0100 100 abababab",
               o_bvalid, o_bwe, o_be, o_baddr, o_bwdata);
    end
    checks++;
    if ({o_stall_ok, o_bus_ok, o_pulse, o_err, o_rdata} !== {4'b1110, 32'h0}) begin
      failures++;
      $display("FAIL sb_rsp: got stall_ok=%b bus_ok=%b pulse=%b err=%b d=%h, want 1 1 1 0 0",
               o_stall_ok, o_bus_ok, o_pulse, o_err, o_rdata);
    end
    run_access(1'b1, 3'b001, 32'h0000_0012, 32'h1234_ABCD, 1, 32'h0, 1'b0);
    checks++;
    if ({o_be, o_baddr, o_bwdata, o_rdata} !== {4'b1100, 32'h10, 32'hABCD_ABCD, 32'h0}) begin
      failures++;
      $display("FAIL sh_bus: got be=%b a=%h d=%h r=%h, want 1100 10 abcdabcd 0",
               o_be, o_baddr, o_bwdata, o_rdata);
    end
  endtask

  task automatic test_load_byte;
    run_access(1'b0, 3'b000, 32'h0000_0203, 32'hFFFF_FFFF, 3, 32'h80FF_0000, 1'b0);
    checks++;
    if ({o_bwe, o_be, o_baddr, o_bwdata} !== {1'b0, 4'b1000, 32'h200, 32'h0}) begin
      failures++;
      $display("FAIL lb_bus: got we=%b be=%b a=%h d=%h, want 0 1000 200 0",
               o_bwe, o_be, o_baddr, o_bwdata);
    end
    checks++;
    if (o_bus_ok !== 1'b1 || o_stall_ok !== 1'b1) begin
      failures++;
      $display("FAIL lb_wait_stable: got bus_ok=%b stall_ok=%b, want 1 1", o_bus_ok, o_stall_ok);
    end
    checks++;
    if (o_pulse !== 1'b1 || o_rdata !== 32'hFFFF_FF80) begin
      failures++;
      $display("FAIL lb_data: got pulse=%b d=%h, want 1 ffffff80", o_pulse, o_rdata);
    end
    run_access(1'b0, 3'b100, 32'h0000_0203, 32'h0, 2, 32'h80FF_0000, 1'b0);
    checks++;
    if (o_rdata !== 32'h0000_0080) begin
      failures++;
      $display("FAIL lbu_data: got %h, want 00000080", o_rdata);
    end
  endtask

  task automatic test_load_half_word;
    run_access(1'b0, 3'b001, 32'h0000_0002, 32'h0, 0, 32'hBEEF_1234, 1'b0);
    checks++;
    if (o_be !== 4'b1100 || o_rdata !== 32'hFFFF_BEEF) begin
      failures++;
      $display("FAIL lh_data: got be=%b d=%h, want 1100 ffffbeef", o_be, o_rdata);
    end
    run_access(1'b0, 3'b101, 32'h0000_0002, 32'h0, 0, 32'hBEEF_1234, 1'b0);
    checks++;
    if (o_rdata !== 32'h0000_BEEF) begin
      failures++;
      $display("FAIL lhu_data: got %h, want 0000beef", o_rdata);
    end
    run_access(1'b0, 3'b010, 32'h0000_0000, 32'h0, 0, 32'hBEEF_1234, 1'b0);
    checks++;
    if (o_be !== 4'b1111 || o_rdata !== 32'hBEEF_1234 || o_err !== 1'b0) begin
      failures++;
      $display("FAIL lw_data: got be=%b d=%h e=%b, want 1111 beef1234 0", o_be, o_rdata, o_err);
    end
  endtask

  task automatic test_bus_error;
    run_access(1'b0, 3'b010, 32'h0000_0040, 32'h0, 0, 32'h0000_0005, 1'b1);
    checks++;
    if (o_pulse !== 1'b1 || o_err !== 1'b1) begin
      failures++;
      $display("FAIL bus_err: got pulse=%b err=%b, want 1 1", o_pulse, o_err);
    end
  endtask

  task automatic test_timeout;
    int n;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0;
    bus_req_ready = 1'b1;
    cyc;
    req_valid = 1'b0;
    cyc;
    bus_req_ready = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 200) begin
      cyc;
      n++;
    end
    checks++;
    if (n != 64) begin
      failures++;
      $display("FAIL timeout_cycles: got %0d, want 64", n);
    end
    checks++;
    if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL timeout_rsp: got err=%b d=%h, want 1 0", rsp_err, rsp_rdata);
    end
    cyc;
    req_valid = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL timeout_idle: got stall=%b rsp_valid=%b, want 1 0", stall, rsp_valid);
    end
    cyc;
    req_valid = 1'b0;
    checks++;
    if (bus_req_valid !== 1'b1) begin
      failures++;
      $display("FAIL timeout_new_req: got bus_req_valid=%b, want 1", bus_req_valid);
    end
    bus_req_ready = 1'b1;
    cyc;
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h0;
    cyc;
    bus_rsp_valid = 1'b0;
    cyc;
  endtask

  task automatic test_back_to_back;
    int pulses, first, second;
    pulses = 0; first = -1; second = -1;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0;
    bus_req_ready = 1'b1; bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h1122_3344; bus_rsp_err = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      cyc;
      if (rsp_valid === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    req_valid = 1'b0; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
    checks++;
    if (pulses != 4 || second - first != 4) begin
      failures++;
      $display("FAIL b2b_rate: got pulses=%0d gap=%0d, want 4 4", pulses, second - first);
    end
    checks++;
    if (rsp_rdata !== 32'h1122_3344) begin
      failures++;
      $display("FAIL b2b_data: got %h, want 11223344", rsp_rdata);
    end
    cyc;
  endtask

  task automatic test_reset_mid;
    logic seen;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0ABC;
    bus_req_ready = 1'b1;
    cyc;
    req_valid = 1'b0;
    cyc;
    bus_req_ready = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (bus_req_valid !== 1'b0 || stall !== 1'b0 || bus_be !== 4'b0000) begin
      failures++;
      $display("FAIL reset_async: got bus_req_valid=%b stall=%b be=%b, want 0 0 0000",
               bus_req_valid, stall, bus_be);
    end
    cyc;
    reset = 1'b1;
    bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'hFFFF_FFFF; bus_rsp_err = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      cyc;
      if (rsp_valid !== 1'b0 || stall !== 1'b0) seen = 1'b1;
    end
    bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0;
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL late_rsp_ignored: got activity=%b, want 0", seen);
    end
    checks++;
    if ({bus_req_valid, bus_we, bus_be, bus_addr, bus_wdata, rsp_valid, rsp_rdata, rsp_err,
         fault_misaligned} !== 105'h0) begin
      failures++;
      $display("FAIL reset_mid_outputs: got a=%h be=%b d=%h r=%h e=%b, want all 0",
               bus_addr, bus_be, bus_wdata, rsp_rdata, rsp_err);
    end
  endtask

  task automatic test_misaligned;
`ifdef LSU_MISALIGN_TRAP_EN
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h6;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL misalign_stall: got %b, want 0", stall);
    end
    cyc;
    req_valid = 1'b0;
    checks++;
    if (fault_misaligned !== 1'b1 || bus_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL misalign_fault: got fault=%b bus_req_valid=%b, want 1 0",
               fault_misaligned, bus_req_valid);
    end
    cyc;
    checks++;
    if (fault_misaligned !== 1'b0 || bus_req_valid !== 1'b0 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL misalign_pulse: got fault=%b bus_req_valid=%b rsp_valid=%b, want 0 0 0",
               fault_misaligned, bus_req_valid, rsp_valid);
    end
`else
    run_access(1'b0, 3'b010, 32'h0000_0006, 32'h0, 0, 32'h89AB_CDEF, 1'b0);
    checks++;
    if (o_baddr !== 32'h4 || o_be !== 4'b1111 || o_rdata !== 32'h89AB_CDEF) begin
      failures++;
      $display("FAIL misalign_ignored: got a=%h be=%b d=%h, want 4 1111 89abcdef",
               o_baddr, o_be, o_rdata);
    end
    checks++;
    if (fault_misaligned !== 1'b0) begin
      failures++;
      $display("FAIL misalign_tied: got %b, want 0", fault_misaligned);
    end
`endif
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_rdata = 32'h0; bus_rsp_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    reset = 1'b1;
    cyc;
    test_store;
    test_load_byte;
    test_load_half_word;
    test_bus_error;
    test_timeout;
    test_back_to_back;
    test_reset_mid;
    test_misaligned;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_bus_master.md
Name: lsu_bus_master

Overview:
- Load/store initiator: takes one memory request per instruction from the execute/memory boundary and drives it onto an external data bus with a valid/ready request channel and a valid response channel.
- Counterpart of the on-chip data-memory responder: generates byte enables and lane-shifted store data, waits out variable bus latency, and sign/zero-extends load data.
- Stalls the pipeline while a transaction is outstanding.

Parameters:
- TIMEOUT, 64, cycles to wait for a response before flagging a bus error (TIMEOUT ≥ 2).
- CNT_W, 7, width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  in  1  memory instruction present (load or store).
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  instr[14:12] size/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
- req_addr  in  32  byte address (ALU result).
- req_wdata  in  32  store data (RD2), right-aligned.
- stall  out  1  hold upstream pipeline.
- rsp_valid  out  1  one-cycle pulse: access complete.
- rsp_rdata  out  32  extended load data; 0 for stores.
- rsp_err  out  1  valid with rsp_valid: bus error or timeout.
- fault_misaligned  out  1  one-cycle pulse on rejected misaligned access.
- bus_req_valid  out  1  request channel valid.
- bus_req_ready  in  1  request accepted.
- bus_addr  out  32  word address, {req_addr[31:2], 2'b00}.
- bus_we  out  1  write strobe.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-shifted store data.
- bus_rsp_valid  in  1  response present.
- bus_rsp_rdata  in  32  raw read word.
- bus_rsp_err  in  1  slave error, qualified by bus_rsp_valid.

Behaviour:
- FSM states: IDLE, REQ, RSP, DONE. Reset puts the FSM in IDLE.
- All registered outputs reset to 0: bus_req_valid, bus_we, bus_be, bus_addr, bus_wdata, rsp_valid, rsp_rdata, rsp_err, fault_misaligned.
- IDLE, req_valid=1:
  - Register addr, funct3 and we.
  - Byte enables: B → 4'b0001 << addr[1:0]; H → 4'b0011 << {addr[1],1'b0}; W → 4'b1111.
  - bus_wdata: B → req_wdata[7:0] replicated in all 4 lanes; H → req_wdata[15:0] replicated in both halves; W → req_wdata unchanged.
  - For loads, bus_be reflects the access size; bus_wdata is don't-care, driven 0.
  - Next state REQ; bus_req_valid=1 from the next cycle.
- REQ: hold bus_* stable while bus_req_valid=1 and bus_req_ready=0. On the handshake, deassert bus_req_valid next cycle, clear the timeout counter, go to RSP.
- RSP:
  - bus_rsp_valid=1 → capture data, go to DONE.
  - Load data: select byte/half by the registered addr[1:0]. funct3 000/001 sign-extend; 100/101 zero-extend; 010 and any undefined code return the full word.
  - rsp_err = bus_rsp_err.
  - Counter reaches TIMEOUT-1 with no response → DONE with rsp_err=1, rsp_rdata=0.
- DONE: rsp_valid=1 for exactly one cycle, stall=0, next state IDLE. A new request is accepted only in IDLE, so back-to-back accesses take a minimum of 4 cycles each.
- Stall: stall = (state==IDLE && req_valid && !misaligned_reject) || state==REQ || state==RSP. Combinational from req_valid in IDLE only.
- Ignored inputs:
  - bus_rsp_valid is ignored outside RSP.
  - A response in the same cycle as the request handshake is illegal and is ignored.
  - req_* are ignored outside IDLE.
- Reset mid-transaction returns immediately to IDLE with bus_req_valid=0. A late bus response after reset is ignored.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: in IDLE, H with addr[0]=1 or W with addr[1:0]≠0 → fault_misaligned pulses for 1 cycle, no bus request, stall=0, no rsp_valid.
- Undefined: the low address bits not used by the size are ignored. H uses addr[1]; W uses the word address. fault_misaligned is tied to 0.

Decomposition:
- Shared package holds:
  - funct3 constants LOAD_BYTE, LOAD_HALF, LOAD_WORD, LOAD_BYTE_UNSIGNED, LOAD_HALF_UNSIGNED, STORE_BYTE, STORE_HALF, STORE_WORD.
  - lsu_state_t enum {IDLE, REQ, RSP, DONE}.
- One sub-module, lsu_load_align: purely combinational byte/half select plus extension from (raw word, addr[1:0], funct3). Reusable by the data-memory stage.

Test Plan:
- SB at addr 0x0000_0102, req_wdata=0x1234_56AB, ready immediate → bus_be=4'b0100, bus_wdata=0xABAB_ABAB, bus_addr=0x100; stall high through RSP, rsp_valid pulses with rsp_rdata=0.
- LB at addr 0x203, rsp_rdata=0x80FF_0000, bus_req_ready held low 3 cycles → bus_* stable for all 3 wait cycles; rsp_rdata=0xFFFF_FF80. Same access with LBU → 0x0000_0080.
- LH at addr 0x2, response 0xBEEF_1234 → 0xFFFF_BEEF; LHU → 0x0000_BEEF; LW at 0x0 → 0xBEEF_1234.
- No response for TIMEOUT=64 cycles → rsp_valid=1, rsp_err=1, rsp_rdata=0, FSM back in IDLE.
- reset driven to 0 during RSP, then bus_rsp_valid arrives after reset is released → FSM in IDLE, no rsp_valid, all outputs 0.
- With LSU_MISALIGN_TRAP_EN defined, LW at 0x6 → fault_misaligned=1 for 1 cycle, bus_req_valid stays 0. Without the macro → bus_addr=0x4, bus_be=4'b1111.
